// File: rtl/insight_tl_pkg.sv
// Shared definitions for the Insight TileLink-UL D-channel responder.
//   - A/D opcode encodings
//   - tl_resp_t: one queued D-channel response, sized for the widest
//     supported configuration (DATA_W up to 64, SOURCE_W up to 16,
//     USER_W up to 8); instances use the low bits.
//   - tl_legal(): request legality (opcode, size, alignment, range).
package insight_tl_pkg;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    localparam logic [2:0] D_ACK         = 3'd0;
    localparam logic [2:0] D_ACK_DATA    = 3'd1;

    localparam int MAX_DATA_W   = 64;
    localparam int MAX_SOURCE_W = 16;
    localparam int MAX_USER_W   = 8;
    localparam int MAX_ADDR_W   = 32;

    typedef struct packed {
        logic [2:0]              opcode;
        logic [2:0]              size;
        logic [MAX_SOURCE_W-1:0] source;
        logic [MAX_USER_W-1:0]   user;
        logic                    denied;
        logic                    corrupt;
        logic [MAX_DATA_W-1:0]   data;
    } tl_resp_t;

    // lg_bytes = log2(bytes per word); depth = words in the array.
    function automatic logic tl_legal(input logic [2:0]            opcode,
                                      input logic [2:0]            size,
                                      input logic [MAX_ADDR_W-1:0] addr,
                                      input int unsigned           lg_bytes,
                                      input int unsigned           depth);
        logic [MAX_ADDR_W-1:0] align_mask;
        logic                  op_ok;
        align_mask = (MAX_ADDR_W'(1) << size) - MAX_ADDR_W'(1);
        op_ok      = (opcode == A_PUT_FULL) || (opcode == A_PUT_PARTIAL) ||
                     (opcode == A_GET);
        return op_ok && (32'(size) <= lg_bytes) &&
               ((addr & align_mask) == '0) &&
               (32'(addr >> lg_bytes) < depth);
    endfunction

endpackage

// File: rtl/insight_tl_resp_fifo.sv
// Two-entry response FIFO.
//   clock/reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push/din      : enqueue; caller only pushes when !full or popping
//   pop/dout      : dequeue head; dout is the head entry, held while not popped
//   count/full/empty : occupancy
// Push and pop on the same edge are both honoured, including when full.
module insight_tl_resp_fifo #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] slot [2];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // When full with push+pop, wr_ptr == rd_ptr: the slot being
            // overwritten is the head being popped this same edge.
            if (push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = slot[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/insight_tl_ul_d_responder.sv
// TileLink-UL slave endpoint: services Get / PutFullData / PutPartialData
// against a DEPTH-word register array and returns AccessAck(Data) on D,
// echoing size/source/user. Up to two responses are buffered so requests
// stream at one per cycle when d_ready is held high.
//   clock, reset_n     : clock, synchronous active-low reset
//   a_*                : A-channel request (valid/ready handshake)
//   d_*                : D-channel response (valid/ready handshake);
//                        all d_* fields read as 0 while d_valid is low
module insight_tl_ul_d_responder
    import insight_tl_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int SOURCE_W = 4,
    parameter int USER_W   = 2,
    parameter int DEPTH    = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    input  logic [USER_W-1:0]   a_user,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [2:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic [USER_W-1:0]   d_user,
    output logic                d_sink,
    output logic                d_denied,
    output logic                d_corrupt,
    output logic [DATA_W-1:0]   d_data
);

    localparam int          NBYTES   = DATA_W / 8;
    localparam int unsigned LG_BYTES = $clog2(NBYTES);
    localparam int unsigned DEPTH_U  = DEPTH;
    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              legal, is_get, is_put;
    logic              a_fire, d_fire;
    logic [1:0]        count;
    logic              full, empty;
    tl_resp_t          rsp_in, rsp_head, d_rsp;
    logic              unused_head;

    assign idx    = IDX_W'(a_address >> LG_BYTES);
    assign is_get = (a_opcode == A_GET);
    assign is_put = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);
    assign legal  = tl_legal(a_opcode, a_size, MAX_ADDR_W'(a_address),
                             LG_BYTES, DEPTH_U);

    assign d_valid = ~empty;
    assign d_fire  = d_valid & d_ready;
    // A slot frees up this edge if the head is leaving.
    assign a_ready = ~full | d_fire;
    assign a_fire  = a_valid & a_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (a_fire && legal && is_put) begin
            for (int b = 0; b < NBYTES; b++)
                if (a_mask[b]) mem[idx][8*b +: 8] <= a_data[8*b +: 8];
        end
    end

    // Get data is sampled at the accept edge; only one A per cycle, so no
    // write can coincide with it.
    always_comb begin
        rsp_in         = '0;
        rsp_in.opcode  = is_get ? D_ACK_DATA : D_ACK;
        rsp_in.size    = a_size;
        rsp_in.source  = MAX_SOURCE_W'(a_source);
        rsp_in.user    = MAX_USER_W'(a_user);
        rsp_in.denied  = ~legal;
        rsp_in.corrupt = is_get & ~legal;
        if (is_get && legal) rsp_in.data = MAX_DATA_W'(mem[idx]);
    end

    insight_tl_resp_fifo #(
        .W($bits(tl_resp_t))
    ) u_resp_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (a_fire),
        .din     (rsp_in),
        .pop     (d_fire),
        .dout    (rsp_head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Stale FIFO slots are never exposed: idle D fields read as zero.
    assign d_rsp     = empty ? '0 : rsp_head;
    assign d_opcode  = d_rsp.opcode;
    assign d_param   = 2'b00;
    assign d_size    = d_rsp.size;
    assign d_source  = d_rsp.source[SOURCE_W-1:0];
    assign d_user    = d_rsp.user[USER_W-1:0];
    assign d_sink    = 1'b0;
    assign d_denied  = d_rsp.denied;
    assign d_corrupt = d_rsp.corrupt;
    assign d_data    = d_rsp.data[DATA_W-1:0];

    // Upper struct bits beyond the configured widths, and count, are unused.
    assign unused_head = ^{d_rsp, count};

endmodule
